// File: rtl/cpu_pkg.sv
// Shared encodings for the fetch stage: next-PC select codes, fetch FSM states, instruction size.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_pkg;

    // Next-PC select codes driven by the control unit
    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_JR     = 2'b11;

    // Fetch state machine encodings (also exported on the State port)
    localparam logic [1:0] ST_BOOT   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;
    localparam logic [1:0] ST_FAULT  = 2'b11;

    // Every instruction is one 32-bit word
    localparam logic [31:0] INSN_BYTES = 32'd4;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC candidate selection plus legality check (alignment and memory bound).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the candidate is taken.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic [31:0] immediate,
    input  logic [25:0] jump_target,
    input  logic [31:0] reg_addr,
    output logic [31:0] next_pc,
    output logic        illegal
);

    // Highest PC that still leaves a whole instruction inside memory
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES) - INSN_BYTES;

    logic [31:0] pc4;
    logic [31:0] imm_bytes;

    assign pc4       = pc + INSN_BYTES;
    // Branch offset is in words; the shift drops the top two bits by design
    assign imm_bytes = immediate << 2;

    // Pick the candidate according to the control-unit select
    always_comb begin
        next_pc = pc4;
        case (pc_src)
            PC_SEQ:    next_pc = pc4;
            PC_BRANCH: next_pc = pc4 + imm_bytes;
            PC_JUMP:   next_pc = {pc4[31:28], jump_target, 2'b00};
            PC_JR:     next_pc = reg_addr;
            default:   next_pc = pc4;
        endcase
    end

    // Misaligned or past the end of instruction memory (unsigned compare)
    always_comb begin
        illegal = (next_pc[1:0] != 2'b00) || (next_pc > LAST_PC);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, next-PC commit, boot/run/halt/fault FSM and retired-instruction counter.
// Latency: one cycle from control inputs to new IAddr; instruction memory read is combinational.
// Backpressure: PCWre=0 stalls the PC; HALTED and FAULT hold everything until Reset.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] Immediate,
    input  logic [25:0] JumpTarget,
    input  logic [31:0] RegAddr,
    input  logic        Halt,
    output logic [31:0] IAddr,
    output logic        InsMemRW,
    output logic [31:0] PC4,
    output logic        Valid,
    output logic        Fault,
    output logic [31:0] FaultAddr,
    output logic [31:0] RetiredCount,
    output logic [1:0]  State
);

    logic [31:0] pc;
    logic [1:0]  state;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] retired_count;
    logic [31:0] cand_pc;
    logic        cand_illegal;

    next_pc_calc #(
        .MEM_BYTES (MEM_BYTES)
    ) u_next_pc_calc (
        .pc          (pc),
        .pc_src      (PCSrc),
        .immediate   (Immediate),
        .jump_target (JumpTarget),
        .reg_addr    (RegAddr),
        .next_pc     (cand_pc),
        .illegal     (cand_illegal)
    );

    assign IAddr        = pc;
    assign InsMemRW     = 1'b1;   // instruction memory is read-only from this stage
    assign PC4          = pc + INSN_BYTES;
    assign Valid        = (state == ST_RUN);
    assign Fault        = fault;
    assign FaultAddr    = fault_addr;
    assign RetiredCount = retired_count;
    assign State        = state;

    // FSM, PC commit, fault capture and retire counting
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc            <= RESET_PC;
            state         <= ST_BOOT;
            fault         <= 1'b0;
            fault_addr    <= 32'd0;
            retired_count <= 32'd0;
        end else begin
            case (state)
                // One bubble so the memory output settles before execution
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (Halt) begin
                        // Halt retires and wins over a stall
                        state         <= ST_HALTED;
                        retired_count <= retired_count + 32'd1;
                    end else if (!PCWre) begin
                        // Stalled: candidate is not consulted, so no fault
                        state <= ST_RUN;
                    end else if (cand_illegal) begin
                        // Keep PC on the faulting instruction for debug
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_addr <= cand_pc;
                    end else begin
                        pc            <= cand_pc;
                        retired_count <= retired_count + 32'd1;
                    end
                end
                // HALTED and FAULT are absorbing until Reset
                default: state <= state;
            endcase
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage directly upstream of the instruction memory in the single-cycle CPU.
- Holds the PC and drives the instruction memory byte address and read/write strobe.
- Selects the next PC (sequential, branch, jump, jump-register) from control-unit inputs.
- Runs a boot/run/halt/fault state machine and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_BYTES, 256, instruction memory size in bytes; legal PCs are 0..MEM_BYTES-4.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- PCWre  input  1  PC write enable; 0 = stall (hold PC).
- PCSrc  input  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jump-register.
- Immediate  input  32  sign-extended branch offset, in words.
- JumpTarget  input  26  J-type target field.
- RegAddr  input  32  rs value for jump-register.
- Halt  input  1  halt instruction decoded this cycle.
- IAddr  output  32  byte address to instruction memory (= PC).
- InsMemRW  output  1  instruction memory RW; constant 1 (read).
- PC4  output  32  PC+4, used as the link value.
- Valid  output  1  the current instruction is architecturally executing.
- Fault  output  1  next-PC fault latched.
- FaultAddr  output  32  offending next-PC value.
- RetiredCount  output  32  count of retired instructions.
- State  output  2  00 BOOT, 01 RUN, 10 HALTED, 11 FAULT.

Behaviour:
- Reset (async, active-high) sets:
  - PC = RESET_PC, State = BOOT, Fault = 0, FaultAddr = 0, RetiredCount = 0.
  - InsMemRW = 1 at all times, including during reset, so the memory is never written.
- Combinational paths:
  - IAddr = PC.
  - PC4 = PC + 4, mod 2^32.
  - Valid = (State == RUN).
- Next-PC candidates:
  - 00: PC4.
  - 01: PC4 + (Immediate << 2), mod 2^32.
  - 10: {PC4[31:28], JumpTarget, 2'b00}.
  - 11: RegAddr.
- The candidate is illegal if next[1:0] != 0, or if, treated as unsigned, it exceeds MEM_BYTES-4.
- BOOT: first rising edge after reset release moves to RUN; PC unchanged. This gives one bubble cycle with Valid = 0 while the memory output settles.
- RUN, rising edge, first matching rule applies:
  - Halt = 1 → HALTED; PC frozen; RetiredCount += 1 (the halt retires). Halt overrides PCWre = 0.
  - PCWre = 0 → PC holds; no legality check; RetiredCount unchanged.
  - Candidate illegal → FAULT; PC frozen at the faulting instruction's PC; FaultAddr = candidate; Fault = 1; RetiredCount unchanged.
  - Otherwise → PC = candidate; RetiredCount += 1, wrapping at 2^32.
- HALTED and FAULT are absorbing: all inputs are ignored and only Reset exits.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronously). Only the first edge after release is a BOOT edge.
- Latency: one cycle from input decision to new IAddr. The instruction memory is combinational, so the instruction is available in the same cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - PCSrc encodings: PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR.
  - State encodings: ST_BOOT, ST_RUN, ST_HALTED, ST_FAULT.
  - Constant INSN_BYTES = 4.
- Natural sub-module: next_pc_calc, combinational. It takes PC, PCSrc, Immediate, JumpTarget and RegAddr, and produces the next-PC candidate and the illegal flag. The FSM, PC register and counter stay in pc_fetch_unit.

Test Plan:
- Reset, then 4 edges with PCSrc = 00 and PCWre = 1:
  - First edge is BOOT → RUN with Valid = 0 and IAddr = 0.
  - Then IAddr = 4, 8, 12.
  - RetiredCount = 3.
- At PC = 0x10, PCSrc = 01, Immediate = 32'hFFFF_FFFD → IAddr = 0x08. At PC = 0x08, Immediate = 5 → IAddr = 0x20.
- At PC = 0x04, PCSrc = 10, JumpTarget = 26'h10 → IAddr = 0x40. At PC = 0x40, PCSrc = 11, RegAddr = 0x80 → IAddr = 0x80.
- At PC = 0x0C, PCSrc = 11:
  - RegAddr = 0x102 → State = FAULT, Fault = 1, FaultAddr = 0x102, IAddr stays 0x0C.
  - Separately, RegAddr = 0x100 (above MEM_BYTES-4 = 0xFC) → same fault behaviour.
- PCWre = 0 for 3 cycles at PC = 0x14 → IAddr stays 0x14 and RetiredCount stays constant. Then Halt = 1 with PCWre = 0 → HALTED, RetiredCount + 1, PC frozen thereafter regardless of inputs.
- Assert Reset asynchronously between edges while in HALTED → State = BOOT, IAddr = RESET_PC, RetiredCount = 0 immediately. InsMemRW = 1 throughout every test.
